// File: rtl/chess_pkg.sv
// Shared board encoding for the move-generation datapath: colours, piece-type
// codes, square/piece typedefs and the scanner state encoding.
package chess_pkg;

  typedef logic [5:0] piece_t;   // {color, type[4:0]}
  typedef logic [5:0] square_t;  // rank*8 + file

  localparam piece_t  EMPTY       = 6'b000000;
  localparam logic    WHITE       = 1'b1;
  localparam logic    BLACK       = 1'b0;
  localparam square_t LAST_SQUARE = 6'd63;

  localparam logic [4:0] PAWN   = 5'b00010;
  localparam logic [4:0] KNIGHT = 5'b00001;
  localparam logic [4:0] KING   = 5'b00100;
  localparam logic [4:0] QUEEN  = 5'b11000;
  localparam logic [4:0] ROOK   = 5'b10000;
  localparam logic [4:0] BISHOP = 5'b01000;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_EVAL,
    S_PRESENT,
    S_DONE
  } scan_state_t;

  function automatic logic is_own_piece(input piece_t code, input logic color);
    return (code != EMPTY) && (code[5] == color);
  endfunction

endpackage

// File: rtl/piece_code_check.sv
// Combinational legality decoder: flags whether a 5-bit piece type is one of
// the six defined codes. Only instantiated when SCAN_ILLEGAL_CHECK_EN is set.
module piece_code_check
  import chess_pkg::*;
(
  input  logic [4:0] piece_type,
  output logic       legal
);

  assign legal = (piece_type == PAWN)  || (piece_type == KNIGHT) ||
                 (piece_type == KING)  || (piece_type == QUEEN)  ||
                 (piece_type == ROOK)  || (piece_type == BISHOP);

endmodule

// File: rtl/board_scanner.sv
// Walks the 64-square board RAM and presents each engine-colour piece to the
// ray transmitter over a valid/ready handshake. Optional: SCAN_ILLEGAL_CHECK_EN.
module board_scanner
  import chess_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       abort,
  input  logic       engine_color,
  output logic [5:0] ram_addr,
  output logic       ram_rd,
  input  logic [5:0] ram_data,
  output logic       color_reg,
  output logic [5:0] piece_reg,
  output logic [5:0] pos_reg,
  output logic       piece_valid,
  input  logic       piece_ready,
  output logic       busy,
  output logic       done,
  output logic [6:0] piece_count
`ifdef SCAN_ILLEGAL_CHECK_EN
  ,
  output logic       illegal_seen
`endif
);

  scan_state_t state, next_state;
  square_t     addr, next_addr;
  logic        accept_start;
  logic        take_piece;
  logic        handshake;
  logic        own_piece;
  logic        code_legal;

  assign own_piece = is_own_piece(ram_data, color_reg);
  assign ram_addr  = addr;

`ifdef SCAN_ILLEGAL_CHECK_EN
  piece_code_check u_code_check (
    .piece_type (ram_data[4:0]),
    .legal      (code_legal)
  );
`else
  assign code_legal = 1'b1;
`endif

  always_comb begin
    // NOTE: every comb output gets a default first so no path infers a latch.
    next_state   = state;
    next_addr    = addr;
    accept_start = 1'b0;
    take_piece   = 1'b0;
    handshake    = 1'b0;

    if (abort && (state != S_IDLE)) begin
      next_state = S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (start && !abort) begin
            accept_start = 1'b1;
            next_addr    = '0;
            next_state   = S_READ;
          end
        end
        S_READ: next_state = S_EVAL;
        S_EVAL: begin
          if (own_piece && code_legal) begin
            take_piece = 1'b1;
            next_state = S_PRESENT;
          end else if (addr == LAST_SQUARE) begin
            next_state = S_DONE;
          end else begin
            next_addr  = addr + 6'd1;
            next_state = S_READ;
          end
        end
        S_PRESENT: begin
          if (piece_ready) begin
            handshake = 1'b1;
            if (addr == LAST_SQUARE) begin
              next_state = S_DONE;
            end else begin
              next_addr  = addr + 6'd1;
              next_state = S_READ;
            end
          end
        end
        S_DONE:  next_state = S_IDLE;
        default: next_state = S_IDLE;
      endcase
    end
  end

  // Outputs are decoded from next_state so they are registered yet line up
  // with the state they describe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      addr        <= '0;
      color_reg   <= 1'b0;
      piece_reg   <= EMPTY;
      pos_reg     <= '0;
      piece_valid <= 1'b0;
      ram_rd      <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      piece_count <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so every flop
      // samples pre-edge values regardless of statement order.
      state       <= next_state;
      addr        <= next_addr;
      ram_rd      <= (next_state == S_READ);
      busy        <= (next_state != S_IDLE);
      done        <= (next_state == S_DONE);
      piece_valid <= (next_state == S_PRESENT);

      if (accept_start) begin
        color_reg   <= engine_color ? WHITE : BLACK;
        piece_count <= '0;
      end else if (handshake) begin
        piece_count <= piece_count + 7'd1;
      end

      if (take_piece) begin
        piece_reg <= ram_data;
        pos_reg   <= addr;
      end else if (next_state != S_PRESENT) begin
        piece_reg <= EMPTY;
        pos_reg   <= '0;
      end
    end
  end

`ifdef SCAN_ILLEGAL_CHECK_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      illegal_seen <= 1'b0;
    end else if (accept_start) begin
      illegal_seen <= 1'b0;
    end else if ((state == S_EVAL) && !abort && own_piece && !code_legal) begin
      illegal_seen <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_board_scanner.sv
// Directed self-checking bench for board_scanner; covers both builds of
// SCAN_ILLEGAL_CHECK_EN.
module tb_board_scanner;
  import chess_pkg::*;

  logic       clk = 1'b0;
  logic       reset, start, abort, engine_color, piece_ready;
  logic [5:0] ram_addr;
  logic       ram_rd;
  logic [5:0] ram_data = '0;
  logic       color_reg;
  logic [5:0] piece_reg, pos_reg;
  logic       piece_valid, busy, done;
  logic [6:0] piece_count;
`ifdef SCAN_ILLEGAL_CHECK_EN
  logic       illegal_seen;
`endif

  piece_t mem [64];
  int vectors = 0;
  int miscompares = 0;
  int cyc;

  board_scanner dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .abort        (abort),
    .engine_color (engine_color),
    .ram_addr     (ram_addr),
    .ram_rd       (ram_rd),
    .ram_data     (ram_data),
    .color_reg    (color_reg),
    .piece_reg    (piece_reg),
    .pos_reg      (pos_reg),
    .piece_valid  (piece_valid),
    .piece_ready  (piece_ready),
    .busy         (busy),
    .done         (done),
    .piece_count  (piece_count)
`ifdef SCAN_ILLEGAL_CHECK_EN
    ,
    .illegal_seen (illegal_seen)
`endif
  );

  always #5 clk = ~clk;

  // Single-port board RAM: one-cycle read latency.
  always @(posedge clk) if (ram_rd) ram_data <= mem[ram_addr];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic clear_board();
    for (int i = 0; i < 64; i++) mem[i] = EMPTY;
  endtask

  task automatic load_initial();
    logic [4:0] back [8];
    back = '{ROOK, KNIGHT, BISHOP, QUEEN, KING, BISHOP, KNIGHT, ROOK};
    clear_board();
    for (int f = 0; f < 8; f++) begin
      mem[f]      = {WHITE, back[f]};
      mem[8 + f]  = {WHITE, PAWN};
      mem[48 + f] = {BLACK, PAWN};
      mem[56 + f] = {BLACK, back[f]};
    end
  endtask

  // Start is sampled on edge 0; on return the bench sits mid-cycle 1.
  task automatic do_start(input logic color);
    start = 1'b1;
    engine_color = color;
    tick();
    start = 1'b0;
    cyc = 1;
  endtask

  initial begin
    int n_hs, done_pulses, done_cyc;
    logic valid_seen, busy_129, busy_130;
    logic [5:0] first_pos, first_piece;

    reset = 1'b1; start = 1'b0; abort = 1'b0; engine_color = 1'b0; piece_ready = 1'b0;
    clear_board();
    tick();
    check("reset_outputs",
          {ram_addr, ram_rd, color_reg, piece_reg, pos_reg, piece_valid, busy, done, piece_count}, 0);
    tick();
    reset = 1'b0;
    tick();

    // Initial position, white to move, ready tied high.
    load_initial();
    piece_ready = 1'b1;
    do_start(WHITE);
    n_hs = 0; done_pulses = 0; done_cyc = -1; first_piece = '0;
    for (; cyc <= 150; cyc++) begin
      if (piece_valid) begin
        if (n_hs == 0) first_piece = piece_reg;
        check("init_pos", pos_reg, n_hs);
        check("init_piece", piece_reg, mem[n_hs]);
        check("init_valid_cycle", cyc, 3 + 3 * n_hs);
        n_hs++;
      end
      if (done) begin done_pulses++; done_cyc = cyc; end
      if (cyc == 146) check("init_busy_after_done", busy, 0);
      tick();
    end
    check("init_first_piece", first_piece, 6'b110000);
    check("init_handshakes", n_hs, 16);
    check("init_done_pulses", done_pulses, 1);
    check("init_done_cycle", done_cyc, 145);
    check("init_piece_count", piece_count, 16);

    // Empty board, black to move.
    clear_board();
    do_start(BLACK);
    valid_seen = 1'b0; done_pulses = 0; done_cyc = -1; busy_129 = 1'b0; busy_130 = 1'b1;
    for (; cyc <= 135; cyc++) begin
      valid_seen |= piece_valid;
      if (done) begin done_pulses++; done_cyc = cyc; end
      if (cyc == 129) busy_129 = busy;
      if (cyc == 130) busy_130 = busy;
      tick();
    end
    check("empty_no_valid", valid_seen, 0);
    check("empty_done_pulses", done_pulses, 1);
    check("empty_done_cycle", done_cyc, 129);
    check("empty_busy_129", busy_129, 1);
    check("empty_busy_130", busy_130, 0);
    check("empty_piece_count", piece_count, 0);
    check("empty_color_reg", color_reg, 0);

    // Backpressure on a lone black queen at square 63.
    clear_board();
    mem[10] = {WHITE, ROOK};
    mem[63] = {BLACK, QUEEN};
    piece_ready = 1'b0;
    do_start(BLACK);
    while (!piece_valid && cyc < 200) begin tick(); cyc++; end
    check("bp_valid_cycle", cyc, 129);
    for (int k = 0; k < 5; k++) begin
      check("bp_hold", {piece_valid, piece_reg, pos_reg}, {1'b1, 6'b011000, 6'd63});
      tick();
    end
    piece_ready = 1'b1;
    check("bp_hold_last", {piece_valid, piece_reg, pos_reg}, {1'b1, 6'b011000, 6'd63});
    tick();
    check("bp_after_accept", {done, piece_valid, piece_reg, pos_reg}, {1'b1, 1'b0, 6'd0, 6'd0});
    check("bp_piece_count", piece_count, 1);
    tick();
    check("bp_idle", {done, busy}, 2'b00);

    // Abort while presenting square 8 (ready high: abort must still win).
    load_initial();
    piece_ready = 1'b1;
    do_start(WHITE);
    while (!(piece_valid && pos_reg == 6'd8) && cyc < 200) begin tick(); cyc++; end
    check("abort_reach_cycle", cyc, 27);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_outputs", {piece_valid, busy, piece_reg, pos_reg}, 0);
    check("abort_count_holds", piece_count, 8);
    done_pulses = 0;
    for (int k = 0; k < 3; k++) begin
      if (done || busy) done_pulses++;
      tick();
    end
    check("abort_no_done", done_pulses, 0);

    // Illegal own-colour code at square 5.
    clear_board();
    mem[5] = 6'b100011;
    mem[7] = {WHITE, BISHOP};
    mem[9] = {BLACK, KING};
    piece_ready = 1'b1;
    do_start(WHITE);
    n_hs = 0; first_pos = '1; first_piece = '1;
    for (; cyc <= 135; cyc++) begin
      if (piece_valid) begin
        if (n_hs == 0) begin first_pos = pos_reg; first_piece = piece_reg; end
        n_hs++;
      end
      tick();
    end
`ifdef SCAN_ILLEGAL_CHECK_EN
    check("illegal_first_pos", first_pos, 7);
    check("illegal_first_piece", first_piece, 6'b101000);
    check("illegal_count", piece_count, 1);
    check("illegal_seen_set", illegal_seen, 1);
`else
    check("illegal_first_pos", first_pos, 5);
    check("illegal_first_piece", first_piece, 6'b100011);
    check("illegal_count", piece_count, 2);
`endif

    // Start (with a colour change) pulsed mid-scan must be ignored.
    load_initial();
    do_start(WHITE);
`ifdef SCAN_ILLEGAL_CHECK_EN
    check("illegal_seen_cleared", illegal_seen, 0);
`endif
    n_hs = 0; done_cyc = -1;
    for (; cyc <= 150; cyc++) begin
      if (cyc == 20) begin start = 1'b1; engine_color = BLACK; end
      if (cyc == 21) start = 1'b0;
      if (piece_valid) n_hs++;
      if (done) done_cyc = cyc;
      tick();
    end
    check("midstart_handshakes", n_hs, 16);
    check("midstart_done_cycle", done_cyc, 145);
    check("midstart_count", piece_count, 16);
    check("midstart_color", color_reg, 1);

    // Asynchronous reset mid-scan.
    load_initial();
    piece_ready = 1'b1;
    do_start(WHITE);
    while (!(piece_valid && pos_reg == 6'd4) && cyc < 200) begin tick(); cyc++; end
    piece_ready = 1'b0;
    tick();
    check("prereset_state", {piece_valid, pos_reg, piece_count}, {1'b1, 6'd4, 7'd4});
    #2 reset = 1'b1;
    #1;
    check("reset_mid_all",
          {ram_addr, ram_rd, color_reg, piece_reg, pos_reg, piece_valid, busy, done, piece_count}, 0);
    check("reset_mid_valid", piece_valid, 0);
`ifdef SCAN_ILLEGAL_CHECK_EN
    check("reset_mid_illegal", illegal_seen, 0);
`endif
    tick();
    reset = 1'b0;
    piece_ready = 1'b1;
    done_pulses = 0;
    for (int k = 0; k < 4; k++) begin
      if (busy || piece_valid || done) done_pulses++;
      tick();
    end
    check("reset_no_resume", done_pulses, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/board_scanner.md
# board_scanner

Sequential front end of the move-generation datapath. On `start`, it walks all 64 board squares in ascending order, reading each one from the single-port board RAM. It presents every square holding an engine-colour piece as a `piece_reg`/`pos_reg` pair with a valid/ready handshake. These outputs feed the ray transmitter directly. When no piece is being presented, the outputs are driven to EMPTY, so the transmitter emits all-zero rays.

## Interface
Parameters:
- none; board size fixed at 64 squares, `pos = rank*8 + file`.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `start` in 1: begin a scan; honoured only in IDLE.
- `abort` in 1: cancel the scan; priority over `start`.
- `engine_color` in 1: side to move (1 = WHITE, 0 = BLACK); sampled on accepted `start`.
- `ram_addr` out 6: board RAM read address.
- `ram_rd` out 1: RAM read strobe; data returns the next cycle.
- `ram_data` in 6: square contents `{color, type[4:0]}`; 000000 = EMPTY.
- `color_reg` out 1: colour latched at start; drives the transmitter's `engine_color`.
- `piece_reg` out 6: presented piece code; 000000 when `piece_valid`=0.
- `pos_reg` out 6: presented square; 0 when `piece_valid`=0.
- `piece_valid` out 1: presentation valid.
- `piece_ready` in 1: downstream accepts.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse at scan completion.
- `piece_count` out 7: handshakes completed in the current or last scan.
- `illegal_seen` out 1: sticky flag; present only with the macro enabled.

## Operation
- Reset values: state IDLE, all outputs 0, internal address 0.
- States:
  - IDLE: on `start` (and no `abort`), latch `color_reg`, clear `piece_count`, clear `illegal_seen`, set address 0, go to READ.
  - READ: `ram_rd`=1, `ram_addr`=current address; go to EVAL.
  - EVAL: classify `ram_data`.
    - Own piece (nonzero, `ram_data[5]==color_reg`): latch it into `piece_reg` and the address into `pos_reg`; go to PRESENT.
    - Otherwise: go to DONE if address==63, else increment the address and go to READ.
  - PRESENT: `piece_valid`=1; `piece_reg`/`pos_reg` held stable until a clock edge with `piece_ready`=1. On that edge, increment `piece_count`, then go to DONE if address==63, else increment the address and go to READ.
  - DONE: `done`=1 for this cycle only; go to IDLE.
- Piece type codes: PAWN 00010, KNIGHT 00001, KING 00100, QUEEN 11000, ROOK 10000, BISHOP 01000.
- Address arithmetic: 6-bit, never wraps. DONE is taken instead of incrementing past 63.
- `piece_count` range 0–64; no saturation needed.
- `start` while busy: ignored.
- `abort` in any non-IDLE state: next state IDLE, `piece_valid` and `piece_reg` cleared, no `done` pulse, `piece_count` holds.
- `abort` and `start` together in IDLE: stay IDLE.
- `reset` mid-scan: immediate return to reset values; the scan is not resumed.

## Timing
- Accepted `start` at edge 0: square n is read (READ) in cycle 1+2n and evaluated (EVAL) in cycle 2+2n, plus any cycles spent in PRESENT for earlier squares.
- Skipped square: 2 cycles.
- Presented square: at least 3 cycles. `piece_valid` rises in cycle 3+2n at the earliest; with `piece_ready` held high it is valid for exactly one cycle.
- Board with no own pieces: `done` in cycle 129, `busy` low from cycle 130.
- `piece_valid` falls in the cycle after the accepting edge. There is no combinational path from `piece_ready` to `piece_valid`.
- All outputs are registered.

## Configuration
- `SCAN_ILLEGAL_CHECK_EN`
  - Defined: in EVAL, an own-colour code whose `type[4:0]` is not one of the six legal codes is skipped like an empty square, and `illegal_seen` is set. The flag stays set until the next accepted `start` or `reset`.
  - Undefined: every nonzero own-colour code is presented, and the `illegal_seen` port is absent.

## Structure
- Shared package `chess_pkg`:
  - EMPTY, WHITE, BLACK constants.
  - The six piece-type codes.
  - 6-bit `piece_t` and `square_t` typedefs.
  - Scanner state enum.
- The transmitter also imports these codes from `chess_pkg`.
- Optional sub-module: `piece_code_check`, a combinational legality decoder, used only under `SCAN_ILLEGAL_CHECK_EN`.
- Everything else lives in one FSM module.

## Test plan
- **Initial position:** white pieces at 0–15, black at 48–63, `engine_color`=1, `piece_ready` tied high. Expect 16 handshakes with `pos_reg` 0..15 in order; `pos_reg` 0 carries `piece_reg` 110000; `piece_count`=16; one `done` pulse.
- **Empty board, `start` at edge 0:** expect no `piece_valid`, `done` in cycle 129 only, `piece_count`=0.
- **Backpressure:** lone black queen 011000 at square 63, `engine_color`=0, `piece_ready` low for 5 cycles. Expect `piece_valid`/`piece_reg`/`pos_reg`=63 stable throughout, handshake on the first ready edge, `done` the next cycle.
- **Abort:** `abort` during PRESENT at square 8. Expect `piece_valid`=0 and `busy`=0 the next cycle, no `done`, `piece_reg`=000000.
- **Illegal code:** 100011 at square 5, `engine_color`=1.
  - With the macro: skipped, `illegal_seen`=1.
  - Without the macro: presented at `pos_reg` 5.
- **Control robustness:**
  - `start` pulsed mid-scan: no restart, `piece_count` unaffected.
  - `reset` asserted mid-scan: all outputs 0 immediately, IDLE.
